svc_sram_cmd_arb: RTL

//  Multi-channel front end for the SRAM cmd/resp stream used by the iCE40 SRAM IO

---
 rtl/svc_sram_cmd_arb_if.sv | 66 ++++++
 rtl/svc_sram_cmd_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/svc_sram_cmd_arb_if.sv
// Bundles every handshake and bus signal of the multi-channel SRAM cmd
// arbiter. The upstream side carries NUM_CH flattened cmd and resp streams,
// and the downstream side carries one cmd and one resp stream.
//   slave  : the arbiter's view. It drives s_cmd_ready, s_resp_*, m_cmd_*
//            and m_resp_ready.
//   master : the environment's view (upstream channels plus the SRAM IO
//            layer), which is the mirror of slave.
// Channel i of a flattened field sits at [i*W +: W].
// The downstream meta is {channel, upstream meta}.
interface svc_sram_cmd_arb_if #(
    parameter int NUM_CH          = 2,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_STRB_WIDTH = 2,
    parameter int SRAM_META_WIDTH = 4,
    parameter int CH_W            = $clog2(NUM_CH)
);
    // upstream cmd
    logic [NUM_CH-1:0]                 s_cmd_valid;
    logic [NUM_CH-1:0]                 s_cmd_ready;
    logic [NUM_CH*SRAM_ADDR_WIDTH-1:0] s_cmd_addr;
    logic [NUM_CH*SRAM_META_WIDTH-1:0] s_cmd_meta;
    logic [NUM_CH-1:0]                 s_cmd_last;
    logic [NUM_CH-1:0]                 s_cmd_wr_en;
    logic [NUM_CH*SRAM_DATA_WIDTH-1:0] s_cmd_wr_data;
    logic [NUM_CH*SRAM_STRB_WIDTH-1:0] s_cmd_wr_strb;
    // upstream resp
    logic [NUM_CH-1:0]                 s_resp_valid;
    logic [NUM_CH-1:0]                 s_resp_ready;
    logic [NUM_CH*SRAM_META_WIDTH-1:0] s_resp_meta;
    logic [NUM_CH-1:0]                 s_resp_last;
    logic [NUM_CH*SRAM_DATA_WIDTH-1:0] s_resp_rd_data;
    // downstream cmd
    logic                              m_cmd_valid;
    logic                              m_cmd_ready;
    logic [SRAM_ADDR_WIDTH-1:0]        m_cmd_addr;
    logic [CH_W+SRAM_META_WIDTH-1:0]   m_cmd_meta;
    logic                              m_cmd_last;
    logic                              m_cmd_wr_en;
    logic [SRAM_DATA_WIDTH-1:0]        m_cmd_wr_data;
    logic [SRAM_STRB_WIDTH-1:0]        m_cmd_wr_strb;
    // downstream resp
    logic                              m_resp_valid;
    logic                              m_resp_ready;
    logic [CH_W+SRAM_META_WIDTH-1:0]   m_resp_meta;
    logic                              m_resp_last;
    logic [SRAM_DATA_WIDTH-1:0]        m_resp_rd_data;

    modport slave (
        input  s_cmd_valid, s_cmd_addr, s_cmd_meta, s_cmd_last, s_cmd_wr_en,
               s_cmd_wr_data, s_cmd_wr_strb, s_resp_ready,
               m_cmd_ready, m_resp_valid, m_resp_meta, m_resp_last, m_resp_rd_data,
        output s_cmd_ready, s_resp_valid, s_resp_meta, s_resp_last, s_resp_rd_data,
               m_cmd_valid, m_cmd_addr, m_cmd_meta, m_cmd_last, m_cmd_wr_en,
               m_cmd_wr_data, m_cmd_wr_strb, m_resp_ready
    );

    modport master (
        output s_cmd_valid, s_cmd_addr, s_cmd_meta, s_cmd_last, s_cmd_wr_en,
               s_cmd_wr_data, s_cmd_wr_strb, s_resp_ready,
               m_cmd_ready, m_resp_valid, m_resp_meta, m_resp_last, m_resp_rd_data,
        input  s_cmd_ready, s_resp_valid, s_resp_meta, s_resp_last, s_resp_rd_data,
               m_cmd_valid, m_cmd_addr, m_cmd_meta, m_cmd_last, m_cmd_wr_en,
               m_cmd_wr_data, m_cmd_wr_strb, m_resp_ready
    );
endinterface

// File: rtl/svc_sram_cmd_arb.sv
// Multi-channel front end for the SRAM cmd/resp stream.
// - Arbitrates NUM_CH upstream cmd streams round-robin into one registered
//   downstream cmd stream.
// - Holds the grant for a whole burst, up to and including the beat with
//   last=1.
// - Tags the downstream meta with the channel index.
// - Routes read responses back to a channel by that tag.
// - Limits the number of read beats in flight per channel to MAX_RD_OUTST.
// Ports:
//   clk : clock
//   rst : synchronous reset, active-high
//   bus : svc_sram_cmd_arb_if.slave
//         upstream side   : s_cmd_* / s_resp_*, NUM_CH channels, flattened
//         downstream side : m_cmd_* / m_resp_*
module svc_sram_cmd_arb #(
    parameter int NUM_CH          = 2,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int SRAM_STRB_WIDTH = 2,
    parameter int SRAM_META_WIDTH = 4,
    parameter int MAX_RD_OUTST    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    svc_sram_cmd_arb_if.slave    bus
);
    localparam int CH_W = $clog2(NUM_CH);
    localparam int AW   = SRAM_ADDR_WIDTH;
    localparam int DW   = SRAM_DATA_WIDTH;
    localparam int SW   = SRAM_STRB_WIDTH;
    localparam int MW   = SRAM_META_WIDTH;
    localparam int OW   = $clog2(MAX_RD_OUTST + 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t              state_reg;
    logic [CH_W-1:0]     lock_ch_reg;
    logic [CH_W-1:0]     rr_ptr_reg;

    // Downstream output register (one entry)
    logic                out_valid_reg;
    logic [AW-1:0]       out_addr_reg;
    logic [CH_W+MW-1:0]  out_meta_reg;
    logic                out_last_reg;
    logic                out_wr_en_reg;
    logic [DW-1:0]       out_wr_data_reg;
    logic [SW-1:0]       out_wr_strb_reg;

    logic [NUM_CH-1:0]   eligible;
    logic [NUM_CH-1:0]   tag_hit;
    logic [CH_W-1:0]     grant;
    logic                grant_found;
    logic [CH_W:0]       scan_idx;
    logic                can_load;
    logic                accept;
    logic [CH_W-1:0]     next_ptr;

    logic [AW-1:0]       sel_addr;
    logic [MW-1:0]       sel_meta;
    logic                sel_last;
    logic                sel_wr_en;
    logic [DW-1:0]       sel_wr_data;
    logic [SW-1:0]       sel_wr_strb;

    logic [CH_W-1:0]     resp_tag;

    // The output register can take a new beat when it is empty or when it is
    // being drained in this cycle. This sustains one beat per clock.
    assign can_load = !out_valid_reg || bus.m_cmd_ready;

    // Grant selection. A locked burst pins the grant to its channel, even when
    // that channel is stalled. Otherwise the grant goes to the first eligible
    // channel found by a cyclic scan that starts at rr_ptr.
    always_comb begin
        grant       = rr_ptr_reg;
        grant_found = 1'b0;
        scan_idx    = '0;
        if (state_reg == ST_LOCKED) begin
            grant       = lock_ch_reg;
            grant_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                scan_idx = {1'b0, rr_ptr_reg} + (CH_W+1)'(k);
                if (scan_idx >= (CH_W+1)'(NUM_CH)) begin
                    scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
                end
                if (!grant_found && eligible[scan_idx[CH_W-1:0]]) begin
                    grant       = scan_idx[CH_W-1:0];
                    grant_found = 1'b1;
                end
            end
        end
    end

    assign accept   = !rst && can_load && grant_found && eligible[grant];
    assign next_ptr = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);

    // Mux of the granted channel's cmd fields
    always_comb begin
        sel_addr    = '0;
        sel_meta    = '0;
        sel_last    = 1'b0;
        sel_wr_en   = 1'b0;
        sel_wr_data = '0;
        sel_wr_strb = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == CH_W'(i)) begin
                sel_addr    = bus.s_cmd_addr[i*AW +: AW];
                sel_meta    = bus.s_cmd_meta[i*MW +: MW];
                sel_last    = bus.s_cmd_last[i];
                sel_wr_en   = bus.s_cmd_wr_en[i];
                sel_wr_data = bus.s_cmd_wr_data[i*DW +: DW];
                sel_wr_strb = bus.s_cmd_wr_strb[i*SW +: SW];
            end
        end
    end

    // Response routing: the tag sits in the top CH_W bits of the meta.
    assign resp_tag = bus.m_resp_meta[MW +: CH_W];

    // A tag that matches no channel is acknowledged here and dropped.
    assign bus.m_resp_ready = (|tag_hit) ? |(tag_hit & bus.s_resp_ready) : 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [OW-1:0] rd_outst_reg;
            logic          rd_inc;
            logic          rd_dec;

            assign tag_hit[gi]  = (resp_tag == CH_W'(gi));
            assign eligible[gi] = bus.s_cmd_valid[gi] &&
                                  (bus.s_cmd_wr_en[gi] || (rd_outst_reg < OW'(MAX_RD_OUTST)));

            assign bus.s_cmd_ready[gi] = !rst && can_load && grant_found &&
                                         (grant == CH_W'(gi)) && eligible[gi];

            assign bus.s_resp_valid[gi]              = !rst && bus.m_resp_valid && tag_hit[gi];
            assign bus.s_resp_meta[gi*MW +: MW]      = bus.m_resp_meta[MW-1:0];
            assign bus.s_resp_last[gi]               = bus.m_resp_last;
            assign bus.s_resp_rd_data[gi*DW +: DW]   = bus.m_resp_rd_data;

            assign rd_inc = bus.s_cmd_valid[gi] && bus.s_cmd_ready[gi] && !bus.s_cmd_wr_en[gi];
            assign rd_dec = bus.m_resp_valid && bus.m_resp_ready && tag_hit[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_outst_reg <= '0;
                end else begin
                    if (rd_inc && !rd_dec) begin
                        rd_outst_reg <= rd_outst_reg + OW'(1);
                    end else if (rd_dec && !rd_inc) begin
                        rd_outst_reg <= rd_outst_reg - OW'(1);
                    end
                    assert (!(rd_dec && !rd_inc && rd_outst_reg == '0));
                    assert (!(rd_inc && !rd_dec && rd_outst_reg == OW'(MAX_RD_OUTST)));
                end
            end
        end
    endgenerate

    // Burst lock FSM and the downstream output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            lock_ch_reg     <= '0;
            rr_ptr_reg      <= '0;
            out_valid_reg   <= 1'b0;
            out_addr_reg    <= '0;
            out_meta_reg    <= '0;
            out_last_reg    <= 1'b0;
            out_wr_en_reg   <= 1'b0;
            out_wr_data_reg <= '0;
            out_wr_strb_reg <= '0;
        end else begin
            if (accept) begin
                if (sel_last) begin
                    state_reg  <= ST_IDLE;
                    rr_ptr_reg <= next_ptr;
                end else begin
                    state_reg   <= ST_LOCKED;
                    lock_ch_reg <= grant;
                end
            end
            if (can_load) begin
                out_valid_reg <= accept;
            end
            if (accept) begin
                out_addr_reg    <= sel_addr;
                out_meta_reg    <= {grant, sel_meta};
                out_last_reg    <= sel_last;
                out_wr_en_reg   <= sel_wr_en;
                out_wr_data_reg <= sel_wr_data;
                out_wr_strb_reg <= sel_wr_strb;
            end
        end
    end

    assign bus.m_cmd_valid   = out_valid_reg;
    assign bus.m_cmd_addr    = out_addr_reg;
    assign bus.m_cmd_meta    = out_meta_reg;
    assign bus.m_cmd_last    = out_last_reg;
    assign bus.m_cmd_wr_en   = out_wr_en_reg;
    assign bus.m_cmd_wr_data = out_wr_data_reg;
    assign bus.m_cmd_wr_strb = out_wr_strb_reg;
endmodule
